// File: rtl/uart_rx_if.sv
// Read-side bundle of the UART receiver: show-ahead byte FIFO req/gnt port plus
// the receiver's one-cycle status pulses.
interface uart_rx_if;
    logic       oreq;
    logic       ognt;
    logic [7:0] odata;
    logic       o_frame_err;
    logic       o_overflow;

    modport master (
        output oreq,
        output odata,
        output o_frame_err,
        output o_overflow,
        input  ognt
    );

    modport slave (
        input  oreq,
        input  odata,
        input  o_frame_err,
        input  o_overflow,
        output ognt
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver feeding a show-ahead byte FIFO with a req/gnt pop port.
// state   | meaning
// IDLE    | line idle, waiting for a low level on the synchronized input
// START   | half-bit wait, then confirm the start bit is still low
// DATA    | sampling 8 data bits LSB-first at bit centres
// STOP    | sampling the stop bit; push, overflow or framing error
// BREAK   | bad stop bit seen, waiting for the line to return high
module uart_rx #(
    parameter int UART_CLK_DIV = 434,
    parameter int FIFO_ASIZE   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_uart_rx,
    uart_rx_if.master bus
);

    localparam int CW    = (UART_CLK_DIV > 2) ? $clog2(UART_CLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_ASIZE;
    localparam logic [CW-1:0] CNT_HALF = CW'(UART_CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(UART_CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      sync_q;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic            push;
    logic            frame_err_nxt;
    logic            overflow_nxt;
    logic            frame_err_q;
    logic            overflow_q;
    logic            cnt_zero;

    logic [FIFO_ASIZE-1:0] wr_ptr;
    logic [FIFO_ASIZE-1:0] rd_ptr;
    logic [7:0]            mem [DEPTH];
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;

    // Two-stage synchronizer; idle-high reset so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
        end
    end

    assign rxs      = sync_q[1];
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            frame_err_q <= frame_err_nxt;
            overflow_q  <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
        overflow_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    cnt_nxt   = CNT_HALF;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt     = CNT_FULL;
                        bit_idx_nxt = '0;
                        state_nxt   = S_DATA;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_nxt   = {rxs, shift[7:1]};
                    cnt_nxt     = CNT_FULL;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        if (fifo_full) begin
                            overflow_nxt = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                        state_nxt = S_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Full is judged on the current pointers, so a same-cycle pop never frees a slot for the push.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr + FIFO_ASIZE'(1)) == rd_ptr);
    assign pop        = !fifo_empty && bus.ognt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_ASIZE'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_ASIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift;
        end
    end

    assign bus.oreq        = !fifo_empty;
    assign bus.odata       = mem[rd_ptr];
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural 8N1 transmitter and FIFO-occupancy model push
// expected bytes; a negedge monitor pops and compares whenever the receiver hands a byte out.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DIV   = 16;
    localparam int ASIZE = 4;
    localparam int DEPTH = (1 << ASIZE) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic ognt  = 1'b0;

    uart_rx_if bus ();
    assign bus.ognt = ognt;

    uart_rx #(.UART_CLK_DIV(DIV), .FIFO_ASIZE(ASIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (rx),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int passes    = 0;
    int cyc       = 0;
    int exp_fe    = 0;
    int exp_ov    = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int gnt_mode  = 0;
    int rise_cyc  = -1;
    int t_start   = 0;
    logic oreq_d  = 1'b0;
    logic [7:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        if (gnt_mode == 0)      ognt = 1'b0;
        else if (gnt_mode == 1) ognt = 1'b1;
        else                    ognt = ($urandom_range(0, 1) == 1);
    end

    // Monitor: every handed-out byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oreq && !oreq_d) rise_cyc = cyc;
            if (bus.o_frame_err) fe_cnt++;
            if (bus.o_overflow) ov_cnt++;
            if (bus.oreq && ognt) begin
                if (sb.size() == 0) check("pop_with_nothing_expected", 1, 0);
                else check("odata", int'(bus.odata), int'(sb.pop_front()));
            end
        end
        oreq_d = rst_n && bus.oreq;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good stop bit stores the byte unless 2^ASIZE-1 bytes are already held.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (sb.size() >= DEPTH) exp_ov++;
            else sb.push_back(b);
        end else begin
            exp_fe++;
        end
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
        drive_bit(stop_ok, DIV);
        rx = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        gnt_mode = 1;
        while (sb.size() != 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_remaining", sb.size(), 0);
        idle(3);
        check("oreq_after_drain", int'(bus.oreq), 0);
        gnt_mode = 0;
        idle(2);
    endtask

    initial begin
        logic [7:0] b;
        idle(3);
        check("reset_oreq", int'(bus.oreq), 0);
        check("reset_frame_err", int'(bus.o_frame_err), 0);
        check("reset_overflow", int'(bus.o_overflow), 0);
        rst_n = 1'b1;
        idle(4);

        // single byte, latency from line edge: 2 sync + DIV/2 + 9*DIV to stop sample, +1 to oreq
        gnt_mode = 0;
        rise_cyc = -1;
        t_start  = cyc;
        send_byte(8'h55, 1'b1);
        idle(DIV);
        check("oreq_rise_latency", rise_cyc - t_start, 2 + DIV/2 + 9*DIV + 1);
        check("single_oreq", int'(bus.oreq), 1);
        check("single_odata", int'(bus.odata), 8'h55);
        gnt_mode = 1;
        @(posedge clk);
        #1;
        gnt_mode = 0;
        check("oreq_after_pop", int'(bus.oreq), 0);
        idle(3);
        check("single_frame_err", fe_cnt, exp_fe);
        check("single_overflow", ov_cnt, exp_ov);
        check("single_consumed", sb.size(), 0);

        // glitch shorter than half a bit
        drive_bit(1'b0, 4);
        rx = 1'b1;
        idle(3 * DIV);
        check("glitch_oreq", int'(bus.oreq), 0);
        check("glitch_frame_err", fe_cnt, 0);
        send_byte(8'hA3, 1'b1);
        idle(DIV);
        drain();

        // framing error followed by a held-low break
        send_byte(8'hA3, 1'b0);
        drive_bit(1'b0, 3 * DIV);
        rx = 1'b1;
        idle(DIV);
        check("break_frame_err_count", fe_cnt, exp_fe);
        check("break_frame_err_once", fe_cnt, 1);
        check("break_no_push", int'(bus.oreq), 0);
        send_byte(8'h3C, 1'b1);
        idle(DIV);
        drain();

        // overflow: 16 bytes into a 15-deep FIFO with no pops
        for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b1);
        idle(DIV);
        check("no_overflow_before_16th", ov_cnt, 0);
        send_byte(8'h0F, 1'b1);
        idle(DIV);
        check("overflow_count", ov_cnt, exp_ov);
        check("overflow_once", ov_cnt, 1);
        check("stored_bytes", sb.size(), 15);
        drain();

        // back-to-back random stream with random pops
        gnt_mode = 2;
        for (int i = 0; i < 100; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(DIV);
        drain();
        check("stream_frame_err", fe_cnt, exp_fe);
        check("stream_overflow", ov_cnt, exp_ov);

        // reset during data bit 3 with two bytes queued
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(DIV);
        check("queued_before_reset", int'(bus.oreq), 1);
        b = 8'h5A;
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 3; i++) drive_bit(b[i], DIV);
        drive_bit(b[3], DIV / 2);
        rst_n = 1'b0;
        #1;
        check("oreq_in_reset", int'(bus.oreq), 0);
        sb.delete();
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2 * DIV);
        check("empty_after_reset", int'(bus.oreq), 0);
        check("reset_no_frame_err", fe_cnt, exp_fe);
        check("reset_no_overflow", ov_cnt, exp_ov);
        send_byte(8'h81, 1'b1);
        idle(DIV);
        check("post_reset_odata", int'(bus.odata), 8'h81);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8N1 frames on `i_uart_rx` in, bytes out through an internal byte FIFO with a req/gnt read port. Mirrors `uart_tx` and uses the same `UART_CLK_DIV` baud convention. It is the host-to-FPGA command path, sitting between the board UART pin and the NFC command/frame builder.

## Interface
- `UART_CLK_DIV`, default 434: clock cycles per bit (baud = clk/UART_CLK_DIV). Legal range ≥ 4.
- `FIFO_ASIZE`, default 4: FIFO pointer width; usable depth is 2^FIFO_ASIZE − 1 bytes.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_uart_rx`, input, 1: serial line, idle high, asynchronous to `clk`.
- `oreq`, output, 1: FIFO non-empty; `odata` is valid.
- `ognt`, input, 1: pop. Ignored when `oreq`=0.
- `odata`, output, 8: head-of-FIFO byte (show-ahead). Don't-care while `oreq`=0.
- `o_frame_err`, output, 1: one-cycle pulse when a stop bit is sampled 0.
- `o_overflow`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Input passes through a 2-FF synchronizer. Both stages reset to 1. Only the synchronized signal `rxs` is used.
- Bit counter `cnt` is sized to hold UART_CLK_DIV−1.
- The FSM has 5 states.
  - IDLE:
    - On `rxs`=0 (line low), load `cnt` = UART_CLK_DIV/2 − 1 (integer division) and go to START.
  - START:
    - Decrement `cnt` each cycle.
    - At `cnt`=0, sample `rxs`. If it is 1, the low pulse was a glitch: go to IDLE, with no output.
    - If it is 0, reload `cnt` = UART_CLK_DIV − 1, clear the bit index, and go to DATA.
  - DATA:
    - At each `cnt`=0, shift `rxs` into the shift register LSB-first, reload `cnt`, and increment the bit index.
    - After bit 7, go to STOP.
  - STOP:
    - At `cnt`=0, sample `rxs`.
    - If it is 1: push the byte if the FIFO is not full, otherwise pulse `o_overflow`. Then go to IDLE.
    - If it is 0: pulse `o_frame_err`, discard the byte, and go to BREAK.
  - BREAK:
    - Stay until `rxs`=1, then go to IDLE. A held-low line therefore produces exactly one `o_frame_err`.
- FIFO:
  - Circular buffer with `wr_ptr`/`rd_ptr` of FIFO_ASIZE bits, wrapping naturally.
  - empty = (`wr_ptr` == `rd_ptr`). full = (`wr_ptr`+1 == `rd_ptr`).
  - `odata` = `mem[rd_ptr]`, read combinationally or from a LUT-RAM.
  - Pop when `oreq` & `ognt`: `rd_ptr`++.
  - Push: `mem[wr_ptr]` ← byte, `wr_ptr`++.
  - Full is evaluated before any same-cycle pop, so a pop never makes room for a push in the same cycle.
  - A simultaneous push and pop on a non-full FIFO are both performed; the count is unchanged.

## Timing
- Reset values:
  - `oreq`=0, `o_frame_err`=0, `o_overflow`=0.
  - FSM in IDLE, pointers 0, synchronizer stages 1.
- Reset mid-frame aborts the frame with no pulses and empties the FIFO.
- All outputs are registered or decoded from registers; no combinational path from `i_uart_rx`.
- Sample times: let t0 be the first cycle with `rxs`=0 in IDLE.
  - Start check at t0 + UART_CLK_DIV/2.
  - Data bit k (0..7) at t0 + UART_CLK_DIV/2 + (k+1)·UART_CLK_DIV.
  - Stop bit at t0 + UART_CLK_DIV/2 + 9·UART_CLK_DIV.
- Push output timing:
  - `oreq` rises the cycle after the stop sample (FIFO previously empty).
  - `o_frame_err` and `o_overflow` are high exactly the cycle after the stop sample.
- Pop timing: `oreq` & `ognt` at edge n updates `odata`/`oreq` at n+1. Back-to-back pops are allowed every cycle.
- Back-to-back frames: after a good stop sample the FSM is in IDLE roughly ½ bit before the next start edge, so continuous 8N1 traffic is received without loss.
- Tolerates about ±4% baud mismatch.

## Test plan
- **Single byte:** UART_CLK_DIV=16; drive 0x55 as 8N1 with `ognt`=0. Required: `oreq` rises 1 cycle after the stop sample; `odata`=0x55; no error pulses. Then pulse `ognt` → `oreq`=0 next cycle.
- **Glitch rejection:** drive the line low for 4 cycles (< DIV/2), then high. Required: FSM returns to IDLE, `oreq` stays 0, no pulses. A following byte 0xA3 is received correctly.
- **Framing error:** send 0xA3 with the stop bit forced 0, then hold the line low for 3 bit times, then release high. Required: exactly one `o_frame_err` pulse, no push; a following byte 0x3C is received correctly.
- **Overflow:** FIFO_ASIZE=4, `ognt`=0. Send 16 bytes 0x00..0x0F.
  - Required: 15 bytes stored; `o_overflow` pulses once, after byte 0x0F.
  - Draining returns 0x00..0x0E in order; then `oreq`=0.
- **Streaming / wrap:** loop `uart_tx` (same UART_CLK_DIV) into `i_uart_rx`; send 100 random bytes with `ognt` randomly toggled. Required: all 100 bytes are read in order, pointers wrap at least 6 times, no error pulses.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of a byte, with 2 bytes already queued. Required: `oreq`=0 immediately, FIFO empty after release; the next complete byte 0x81 is received correctly.
